seq_alu: RTL and testbench

- Parametrised, clocked successor of the 4-bit combinational ALU.
- Keeps the same 3-bit opcode map, generalised to WIDTH bits.
- Adds a valid/ready handshake, iterative multi-cycle multiply and divide, and status flags (zero, carry/borrow, overflow, divide-by-zero).
- Sits between the operand register file and the writeback stage, and can be back-pressured by writeback.

---
 rtl/seq_alu.sv | 223 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Clocked, handshaked ALU with iterative shift-add multiply and restoring divide.
// Optional SEQ_ALU_HI_RESULT_EN adds f_hi (high product / remainder).
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       oc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz
`ifdef SEQ_ALU_HI_RESULT_EN
  ,
  output logic [WIDTH-1:0] f_hi
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   f_q, f_d;
  logic               z_q, z_d;
  logic               c_q, c_d;
  logic               v_q, v_d;
  logic               dz_q, dz_d;
  logic               res_load;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] iter_next;

  // acc holds {high, low}: mul = {partial product, remaining multiplier},
  // div = {partial remainder, dividend bits shifting into quotient bits}.
  always_comb begin
    add_sum   = {1'b0, a} + {1'b0, b};
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
    mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    trial     = rem_sh - {1'b0, m_q};
    div_next  = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                             : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    iter_next = div_q ? div_next : mul_next;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    m_d      = m_q;
    acc_d    = acc_q;
    f_d      = f_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
    dz_d     = dz_q;
    res_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          c_d      = 1'b0;
          v_d      = 1'b0;
          dz_d     = 1'b0;
          res_load = 1'b1;
          state_d  = DONE;
          case (oc)
            OP_ADD: begin
              f_d = add_sum[WIDTH-1:0];
              c_d = add_sum[WIDTH];
            end
            OP_SUB: begin
              f_d = a - b;
              c_d = (a < b);
            end
            OP_MUL: begin
              res_load = 1'b0;
              state_d  = BUSY;
              div_d    = 1'b0;
              m_d      = a;
              acc_d    = {{WIDTH{1'b0}}, b};
              cnt_d    = CW'(WIDTH);
            end
            OP_DIV: begin
              if (b == '0) begin
                f_d  = '1;
                dz_d = 1'b1;
              end else begin
                res_load = 1'b0;
                state_d  = BUSY;
                div_d    = 1'b1;
                m_d      = b;
                acc_d    = {{WIDTH{1'b0}}, a};
                cnt_d    = CW'(WIDTH);
              end
            end
            OP_NOT:  f_d = ~a;
            OP_XOR:  f_d = a ^ b;
            OP_OR:   f_d = a | b;
            default: f_d = a & b;
          endcase
          if (res_load) begin
            z_d = (f_d == '0);
          end else begin
            // Flags of the previous result stay until the iteration completes.
            c_d  = c_q;
            v_d  = v_q;
            dz_d = dz_q;
          end
        end
      end
      BUSY: begin
        acc_d = iter_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          res_load = 1'b1;
          f_d      = iter_next[WIDTH-1:0];
          z_d      = (iter_next[WIDTH-1:0] == '0);
          c_d      = 1'b0;
          v_d      = ~div_q & (iter_next[2*WIDTH-1:WIDTH] != '0);
          dz_d     = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      f_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      f_q     <= f_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      dz_q    <= dz_d;
    end
  end

`ifdef SEQ_ALU_HI_RESULT_EN
  logic [WIDTH-1:0] hi_q, hi_d;

  // High half of acc is the product top on mul and the remainder on div.
  always_comb begin
    hi_d = hi_q;
    if (res_load) begin
      if (state_q == BUSY) begin
        hi_d = iter_next[2*WIDTH-1:WIDTH];
      end else if (oc == OP_DIV) begin
        hi_d = a;
      end else begin
        hi_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
    end else begin
      hi_q <= hi_d;
    end
  end

  assign f_hi = hi_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign f         = f_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign flag_dz   = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=4 (checks f_hi when
// SEQ_ALU_HI_RESULT_EN is defined).
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] oc;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] f;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;
  logic       flag_dz;
`ifdef SEQ_ALU_HI_RESULT_EN
  logic [3:0] f_hi;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .oc        (oc),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_dz   (flag_dz)
`ifdef SEQ_ALU_HI_RESULT_EN
    ,
    .f_hi      (f_hi)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts one op, then waits (bounded) for out_valid; lat counts the accept cycle as 1.
  task automatic issue(input logic [2:0] op, input logic [3:0] va, input logic [3:0] vb,
                       output int lat, output int rdy_seen);
    oc       = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a        = 4'h0;
    b        = 4'h0;
    lat      = 1;
    rdy_seen = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen++;
      step();
      lat++;
    end
  endtask

  task automatic result(input string tag, input int lat, input int exp_lat,
                        input logic [3:0] ef, input logic ez, input logic ec,
                        input logic ev, input logic edz, input logic [3:0] ehi);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_f"}, f, ef);
    chk({tag, "_z"}, flag_z, ez);
    chk({tag, "_c"}, flag_c, ec);
    chk({tag, "_v"}, flag_v, ev);
    chk({tag, "_dz"}, flag_dz, edz);
`ifdef SEQ_ALU_HI_RESULT_EN
    chk({tag, "_hi"}, f_hi, ehi);
`else
    if (ehi != ehi) chk({tag, "_hi"}, 0, 0);
`endif
    chk({tag, "_rdy_done"}, in_ready, 1'b0);
    step();
    chk({tag, "_idle_valid"}, out_valid, 1'b0);
    chk({tag, "_idle_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    int rdy;
    int bad;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    oc        = 3'b000;
    a         = 4'h0;
    b         = 4'h0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_f", f, 4'h0);
    chk("rst_flags", {flag_z, flag_c, flag_v, flag_dz}, 4'b0000);

    issue(3'b000, 4'd7, 4'd9, lat, rdy);
    result("add_7_9", lat, 1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);

    issue(3'b001, 4'd3, 4'd5, lat, rdy);
    result("sub_3_5", lat, 1, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

    issue(3'b001, 4'd5, 4'd5, lat, rdy);
    result("sub_5_5", lat, 1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);

    issue(3'b010, 4'd7, 4'd3, lat, rdy);
    chk("mul_7_3_busy_ready", rdy, 0);
    result("mul_7_3", lat, 5, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1);

    issue(3'b010, 4'd3, 4'd5, lat, rdy);
    result("mul_3_5", lat, 5, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    issue(3'b010, 4'hF, 4'hF, lat, rdy);
    result("mul_F_F", lat, 5, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hE);

    issue(3'b011, 4'd13, 4'd4, lat, rdy);
    chk("div_13_4_busy_ready", rdy, 0);
    result("div_13_4", lat, 5, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);

    issue(3'b011, 4'd9, 4'd0, lat, rdy);
    result("div_9_0", lat, 1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 4'h9);

    issue(3'b000, 4'd2, 4'd3, lat, rdy);
    result("add_2_3", lat, 1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    issue(3'b011, 4'd15, 4'd1, lat, rdy);
    result("div_15_1", lat, 5, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    issue(3'b011, 4'd3, 4'd7, lat, rdy);
    result("div_3_7", lat, 5, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3);

    issue(3'b101, 4'hC, 4'hA, lat, rdy);
    result("xor", lat, 1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    issue(3'b110, 4'hC, 4'hA, lat, rdy);
    result("or", lat, 1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    issue(3'b111, 4'hC, 4'hA, lat, rdy);
    result("and", lat, 1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Backpressure: result must hold and no new op may be accepted meanwhile.
    out_ready = 1'b0;
    issue(3'b100, 4'h5, 4'h0, lat, rdy);
    chk("bp_lat", lat, 1);
    oc       = 3'b000;
    a        = 4'h3;
    b        = 4'h3;
    in_valid = 1'b1;
    bad      = 0;
    for (int i = 0; i < 10; i++) begin
      if (f !== 4'hA || out_valid !== 1'b1 || in_ready !== 1'b0 ||
          flag_z !== 1'b0 || flag_c !== 1'b0) bad++;
      step();
    end
    chk("bp_hold_violations", bad, 0);
    in_valid  = 1'b0;
    chk("bp_f", f, 4'hA);
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_ready", in_ready, 1'b1);
    chk("bp_release_f", f, 4'hA);

    // Reset two cycles into a multiply aborts it.
    oc       = 3'b010;
    a        = 4'd7;
    b        = 4'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("abort_busy_ready", in_ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_ready", in_ready, 1'b1);
    chk("abort_f", f, 4'h0);
    chk("abort_flags", {flag_z, flag_c, flag_v, flag_dz}, 4'b0000);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) bad++;
      step();
    end
    chk("abort_no_result", bad, 0);

    issue(3'b000, 4'd1, 4'd1, lat, rdy);
    result("add_1_1", lat, 1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Reset wins over a simultaneous accept.
    oc       = 3'b000;
    a        = 4'd4;
    b        = 4'd4;
    in_valid = 1'b1;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_prio_valid", out_valid, 1'b0);
    chk("rst_prio_ready", in_ready, 1'b1);
    chk("rst_prio_f", f, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
